instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage feeding instruction_decode: holds the program counter, issues one instruction read at a time to the instruction memory port, and presents inst plus PC+4 to decode with an if_write/id_read handshake.
- Honours back-end freeze (stall, executebusy, membusy) and accepts a branch redirect from execute, squashing any in-flight or held instruction.

Parameters:
BUS_DATA_WIDTH, 64, width of PC, memory address and out_PCplus4
BUS_INST_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  BUS_DATA_WIDTH  read address, valid while imem_req=1
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  BUS_INST_WIDTH  returned instruction
inst  output  BUS_INST_WIDTH  instruction to decode
out_PCplus4  output  BUS_DATA_WIDTH  address of inst + 4
if_write  output  1  inst/out_PCplus4 valid for decode
id_read  input  1  decode consumes held instruction
stall, executebusy, membusy  input  1 each  back-end freeze; freeze = OR of the three
br_valid  input  1  redirect request (one-cycle pulse)
br_target  input  BUS_DATA_WIDTH  redirect PC

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, inst=0, out_PCplus4=0, if_write=0. First request issued the cycle after reset deasserts.
- All outputs registered. imem_addr = pc while in FETCH; imem_req=1 only in FETCH.
- States:
  FETCH: imem_req=1. Hold imem_req and imem_addr stable until imem_gnt. On gnt -> WAIT.
  WAIT: on imem_rvalid: inst<=imem_rdata, out_PCplus4<=pc+4, if_write<=1, pc<=pc+4 -> HOLD.
  HOLD: if_write=1, inst/out_PCplus4 stable. On id_read=1 and freeze=0: if_write<=0 -> FETCH. id_read while freeze=1 is ignored.
  DROP: discard one outstanding response. On imem_rvalid -> FETCH; data never reaches inst.
- Minimum latency: gnt in the request cycle, rvalid the next cycle -> if_write high 2 cycles after first imem_req. Throughput at most 1 instruction per 3 cycles; no prefetch.
- Redirect (br_valid=1) has priority over freeze and id_read; pc<=br_target in every state.
  FETCH without gnt: next request uses br_target.
  FETCH with gnt: -> DROP.
  WAIT with rvalid: response discarded -> FETCH.
  WAIT without rvalid: -> DROP.
  HOLD: if_write<=0, held instruction squashed -> FETCH.
  DROP: stays DROP until rvalid.
- pc+4 wraps modulo 2^BUS_DATA_WIDTH; no overflow flag.
- freeze does not stall the memory handshake in FETCH/WAIT; it only blocks HOLD->FETCH.
- imem_rvalid in FETCH or HOLD (protocol violation) is ignored.

Optional Feature:
- Macro IF_ALIGN_CHECK_EN.
- Defined: adds output if_misaligned (1 bit, reset 0). A br_valid whose br_target[1:0]!=0 sets if_misaligned=1 (sticky until reset), squashes as a normal redirect, then parks in FETCH with imem_req=0.
- Undefined: no port; br_target low bits used as-is.

Test Plan:
- Reset release, RESET_PC=0x100, gnt immediate, rvalid +1 cycle, id_read held 1 -> addrs 0x100, 0x104, 0x108; out_PCplus4 0x104, 0x108, 0x10C; if_write high 2 cycles after first req.
- gnt delayed 3 cycles -> imem_req/imem_addr stable for all 4 cycles; single fetch only.
- In HOLD, stall=1 for 5 cycles with id_read=1 -> if_write and inst unchanged; advances the cycle after stall drops.
- br_valid, target 0x200, in WAIT before rvalid -> next rvalid dropped (if_write stays 0); next imem_addr=0x200.
- br_valid in HOLD with id_read=1 same cycle -> if_write=0 next cycle; next request at br_target.
- Async reset=0 mid-WAIT -> outputs zero immediately; pc=RESET_PC; late rvalid after reset ignored.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). Each request is held with its address
// until it is accepted by imem_gnt. The instruction comes back later with
// imem_rvalid.
interface instruction_fetch_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_INST_WIDTH = 32
);
  logic                      imem_req;
  logic [BUS_DATA_WIDTH-1:0] imem_addr;
  logic                      imem_gnt;
  logic                      imem_rvalid;
  logic [BUS_INST_WIDTH-1:0] imem_rdata;

  // Fetch-stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Instruction-memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: the fetch stage in front of instruction_decode.
// - Holds the PC and issues one instruction read at a time on the imem bus.
// - Presents inst and out_PCplus4 to decode with the if_write/id_read handshake.
// - A back-end freeze (stall | executebusy | membusy) only holds an instruction
//   that is already in HOLD.
// - A br_valid redirect squashes any in-flight or held instruction.
// Optional build macro IF_ALIGN_CHECK_EN adds the sticky if_misaligned output.
// A redirect to a target that is not word-aligned sets if_misaligned and parks
// the stage in FETCH with no request.
module instruction_fetch #(
  parameter int unsigned               BUS_DATA_WIDTH = 64,
  parameter int unsigned               BUS_INST_WIDTH = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_if.master       imem,
  output logic [BUS_INST_WIDTH-1:0] inst,
  output logic [BUS_DATA_WIDTH-1:0] out_PCplus4,
  output logic                      if_write,
  input  logic                      id_read,
  input  logic                      stall,
  input  logic                      executebusy,
  input  logic                      membusy,
  input  logic                      br_valid,
`ifdef IF_ALIGN_CHECK_EN
  input  logic [BUS_DATA_WIDTH-1:0] br_target,
  output logic                      if_misaligned
`else
  input  logic [BUS_DATA_WIDTH-1:0] br_target
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding or about to be issued
    ST_WAIT  = 2'd1,  // request granted, waiting for the instruction
    ST_HOLD  = 2'd2,  // instruction presented to decode
    ST_DROP  = 2'd3   // squashed request in flight; discard its response
  } state_e;

  state_e                    state_q;
  logic [BUS_DATA_WIDTH-1:0] pc_q;
  logic                      imem_req_q;
  logic [BUS_DATA_WIDTH-1:0] imem_addr_q;
  logic [BUS_INST_WIDTH-1:0] inst_q;
  logic [BUS_DATA_WIDTH-1:0] pcplus4_q;
  logic                      if_write_q;

  logic                      freeze;
  logic [BUS_DATA_WIDTH-1:0] pc_redir;
  logic [BUS_DATA_WIDTH-1:0] pc_inc;
  logic                      can_issue;

  assign freeze   = stall | executebusy | membusy;
  // Holds the PC that the next request uses, with any redirect this cycle applied.
  assign pc_redir = br_valid ? br_target : pc_q;
  // The PC increment wraps silently at the top of the address space.
  assign pc_inc   = pc_q + BUS_DATA_WIDTH'(4);

`ifdef IF_ALIGN_CHECK_EN
  logic misaligned_q;
  logic br_misaligned;

  assign br_misaligned = br_valid && (br_target[1:0] != 2'b00);
  // The flag is checked in the same cycle as the redirect, so the squash parks
  // the stage immediately.
  assign can_issue     = !(misaligned_q || br_misaligned);
  assign if_misaligned = misaligned_q;

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned_q <= 1'b0;
    end else if (br_misaligned) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign can_issue = 1'b1;
`endif

  // Fetch FSM: PC, the memory request and the decode-side outputs are all registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      inst_q      <= '0;
      pcplus4_q   <= '0;
      if_write_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (br_valid) begin
            pc_q <= br_target;
            if (imem_req_q && imem.imem_gnt) begin
              // The old request was accepted and cannot be withdrawn.
              // Its response must be swallowed.
              imem_req_q <= 1'b0;
              state_q    <= ST_DROP;
            end else begin
              imem_req_q  <= can_issue;
              imem_addr_q <= br_target;
            end
          end else if (!imem_req_q) begin
            // Issue a request, for example the first one after reset.
            if (can_issue) begin
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_q;
            end
          end else if (imem.imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (br_valid) begin
            pc_q <= br_target;
            if (imem.imem_rvalid) begin
              // The stale response arrives now and is discarded.
              // Refetch from the target at once.
              imem_req_q  <= can_issue;
              imem_addr_q <= br_target;
              state_q     <= ST_FETCH;
            end else begin
              state_q <= ST_DROP;
            end
          end else if (imem.imem_rvalid) begin
            inst_q     <= imem.imem_rdata;
            pcplus4_q  <= pc_inc;
            pc_q       <= pc_inc;
            if_write_q <= 1'b1;
            state_q    <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (br_valid) begin
            pc_q        <= br_target;
            if_write_q  <= 1'b0;
            imem_req_q  <= can_issue;
            imem_addr_q <= br_target;
            state_q     <= ST_FETCH;
          end else if (id_read && !freeze) begin
            // Going straight into FETCH with the request raised sustains
            // one instruction every three cycles.
            if_write_q  <= 1'b0;
            imem_req_q  <= can_issue;
            imem_addr_q <= pc_q;
            state_q     <= ST_FETCH;
          end
        end

        ST_DROP: begin
          if (br_valid) begin
            pc_q <= br_target;
          end
          if (imem.imem_rvalid) begin
            imem_req_q  <= can_issue;
            imem_addr_q <= pc_redir;
            state_q     <= ST_FETCH;
          end
        end

        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign inst           = inst_q;
  assign out_PCplus4    = pcplus4_q;
  assign if_write       = if_write_q;

endmodule
